// File: rtl/sar_search.sv
// Successive-approximation search driving an external l/e/g comparator, MSB first.
// Optional macro SAR_SEARCH_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_l,
    input  logic             cmp_e,
    input  logic             cmp_g,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] cur_bit;
    logic [WIDTH-1:0] decided;
    logic             cmp_ok;

    // A well-behaved comparator asserts exactly one of its three outputs.
    function automatic logic is_onehot(input logic l, input logic e, input logic g);
        logic ok;
        case ({l, e, g})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign cur_bit = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
    assign decided = cmp_g ? (guess_q & ~cur_bit) : guess_q;
    assign cmp_ok  = is_onehot(cmp_l, cmp_e, cmp_g);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        idx_d    = idx_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TRIAL;
                    guess_d = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d   = IDX_W'(WIDTH - 1);
                    err_d   = 1'b0;
                end
            end
            TRIAL: begin
                if (!cmp_ok) begin
                    err_d    = 1'b1;
                    result_d = guess_q;
                    state_d  = DONE;
                end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                else if (cmp_e) begin
                    result_d = guess_q;
                    state_d  = DONE;
                end
`endif
                else if (idx_q != '0) begin
                    guess_d = decided | (cur_bit >> 1);
                    idx_d   = idx_q - IDX_W'(1);
                end else begin
                    // guess keeps the last trial value; only result takes the decision.
                    result_d = decided;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q == TRIAL);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Randomized self-checking bench for sar_search with a behavioural comparator and search model.
module tb_sar_search;

    localparam int W = 8;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cmp_l, cmp_e, cmp_g;
    logic [W-1:0] guess, result;
    logic         busy, done, err;
    logic [W-1:0] target;
    logic         force_bad;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        cmp_l = force_bad | (guess < target);
        cmp_g = force_bad | (guess > target);
        cmp_e = !force_bad && (guess == target);
    end

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_l  (cmp_l),
        .cmp_e  (cmp_e),
        .cmp_g  (cmp_g),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bad_at / rst_at: 1-based TRIAL cycle to corrupt or reset in (0 = never).
    task automatic run_search(input logic [W-1:0] tgt, input int bad_at, input int rst_at,
                              input bit poke);
        logic [W-1:0] q[$];
        logic [W-1:0] acc;
        logic [W-1:0] trial;
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           n;
        bit           finished;

        // Reference: classic binary search over the value range, top bit first.
        acc = '0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = acc | (W'(1) << b);
            q.push_back(trial);
            if (EARLY && trial == tgt) break;
            if (trial <= tgt) acc = trial;
        end
        exp_res = tgt;
        exp_err = 1'b0;
        if (bad_at > 0 && bad_at <= q.size()) begin
            while (q.size() > bad_at) void'(q.pop_back());
            exp_res = q[bad_at-1];
            exp_err = 1'b1;
        end

        target = tgt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            force_bad = 1'b0;
            start = 1'b0;
            if (done) begin
                finished = 1'b1;
            end else if (busy) begin
                if (n < q.size()) check("guess", guess, q[n]);
                else check("trial_overrun", n, q.size());
                check("err_in_trial", err, 0);
                n++;
                if (n == rst_at) begin
                    rst = 1'b1;
                    #1;
                    check("rst_guess", guess, 0);
                    check("rst_result", result, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_err", err, 0);
                    @(negedge clk);
                    check("rst_hold_done", done, 0);
                    rst = 1'b0;
                    @(negedge clk);
                    check("post_rst_done", done, 0);
                    check("post_rst_busy", busy, 0);
                    return;
                end
                if (n == bad_at) force_bad = 1'b1;
                if (poke && n == 3) start = 1'b1;
            end else begin
                check("busy_gap", busy, 1);
            end
            if (!finished) @(negedge clk);
        end
        if (!finished) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("trial_count", n, q.size());
        check("result", result, exp_res);
        check("err", err, exp_err);
        check("busy_in_done", busy, 0);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("result_held", result, exp_res);
        @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        force_bad = 1'b0;
        target = '0;
        #1;
        check("reset_guess", guess, 0);
        check("reset_result", result, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_search(8'hA5, 0, 0, 1'b0);
        run_search(8'h00, 0, 0, 1'b0);
        run_search(8'hFF, 0, 0, 1'b0);
        run_search(8'h80, 0, 0, 1'b0);
        run_search(8'hA5, 3, 0, 1'b0);
        run_search(8'h5A, 0, 0, 1'b0);
        run_search(8'hC3, 0, 4, 1'b0);
        run_search(8'h3C, 0, 0, 1'b0);
        run_search(8'h6E, 0, 0, 1'b1);

        for (int t = 0; t < (1 << W); t++) run_search(W'(t), 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = $urandom_range(0, 3);
            run_search(W'($urandom), (mode == 1) ? $urandom_range(1, 8) : 0,
                       (mode == 2) ? $urandom_range(1, 8) : 0, mode == 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 8: width of the search value; legal range 2 to 16.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 cmp_l  input  1  external comparator result: guess < target.
REQ-006 cmp_e  input  1  external comparator result: guess == target.
REQ-007 cmp_g  input  1  external comparator result: guess > target.
REQ-008 guess  output  WIDTH  registered trial value driven to the external comparator's first operand.
REQ-009 busy  output  1  high while in TRIAL.
REQ-010 done  output  1  one-cycle pulse when a search completes.
REQ-011 result  output  WIDTH  final value; held until the next search completes.
REQ-012 err  output  1  comparator protocol error flag for the last search; held until the next start.

Function
REQ-013 The block SHALL be the consumer of a combinational l/e/g comparator (target on its other operand) and SHALL find the target by successive approximation, MSB first.
REQ-014 FSM states SHALL be IDLE, TRIAL, DONE; the reset state is IDLE.
REQ-015 IDLE with start=1 -> TRIAL; set guess to only bit WIDTH-1 high; set bit index to WIDTH-1; clear err.
REQ-016 Each TRIAL cycle SHALL sample cmp_l/cmp_e/cmp_g at the rising edge for the guess currently driven.
REQ-017 cmp_g=1: clear the current bit. cmp_l=1 or cmp_e=1: keep the current bit.
REQ-018 If the bit index > 0, the block SHALL set the next lower bit and decrement the index.
REQ-019 If the bit index = 0, the block SHALL load result with the decided value and go to DONE.
REQ-020 Protocol error: if in any TRIAL cycle the inputs are not exactly one-hot, the block SHALL set err=1, load result with the current guess, and go to DONE.
REQ-021 Without early exit, latency SHALL be exactly WIDTH TRIAL cycles; done SHALL assert in the cycle after the last TRIAL cycle.
REQ-022 DONE SHALL last one cycle (done=1, busy=0), then return to IDLE; guess holds its last value.
REQ-023 start SHALL be ignored in TRIAL and DONE; it is not queued.
REQ-024 At every target value 0 to 2^WIDTH-1, result SHALL equal the target; target 0 clears every bit; target all-ones keeps every bit.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, and set guess, result, bit index, busy, done and err to 0, including when asserted mid-search.
REQ-026 After rst deasserts, the block SHALL wait in IDLE for a fresh start; an aborted search produces no done pulse.

Configuration
REQ-027 Macro SAR_SEARCH_EARLY_EXIT_EN defined: in TRIAL, a one-hot cmp_e=1 SHALL load result with the current guess and go to DONE immediately.
REQ-028 With the macro defined, latency SHALL be 1 to WIDTH TRIAL cycles.
REQ-029 Macro undefined: cmp_e only keeps the bit, and latency SHALL be always exactly WIDTH TRIAL cycles.
REQ-030 Macro undefined: result SHALL be identical to the macro-defined build for every target.

Verification (WIDTH=8; bench comparator models target vs guess)
REQ-031 target 0xA5; pulse start -> busy high for 8 cycles; guess sequence 80,C0,A0,B0,A8,A4,A6,A5; done on the 9th cycle after start; result=A5, err=0.
REQ-032 targets 0x00 and 0xFF -> result 00 and FF; err=0; 8 TRIAL cycles each.
REQ-033 target 0x80 -> with SAR_SEARCH_EARLY_EXIT_EN: done after 1 TRIAL cycle, result=80; without it: 8 TRIAL cycles, result=80.
REQ-034 Force cmp_l=cmp_g=1 in the 3rd TRIAL cycle -> err=1, result=current guess, done next cycle; err clears on the next start.
REQ-035 Assert rst in the 4th TRIAL cycle -> all outputs 0 at once, no done pulse; a later start with target 0x3C completes to 3C.
REQ-036 Pulse start again mid-search, and in the DONE cycle -> ignored; the sequence and result of the running search are unchanged.
